// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS32 controller: FSM states,
// opcode/funct constants, datapath select encodings and the control word.
package mips_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_I_EXEC    = 4'd9,
    S_I_WB      = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12,
    S_JAL       = 4'd13,
    S_JR        = 4'd14,
    S_TRAP      = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_FUNCT, ALU_IMM} alu_op_t;
  typedef enum logic [1:0] {SRCB_B, SRCB_FOUR, SRCB_IMM, SRCB_IMM_SH2} alu_src_b_t;
  typedef enum logic [1:0] {PCSRC_ALU, PCSRC_ALUOUT, PCSRC_JUMP, PCSRC_REG} pc_source_t;
  typedef enum logic [1:0] {RDST_RT = 2'b00, RDST_RD = 2'b01, RDST_RA = 2'b10} reg_dst_t;
  typedef enum logic [1:0] {M2R_ALUOUT = 2'b00, M2R_MDR = 2'b01, M2R_PC = 2'b10} mem_to_reg_t;

  typedef struct packed {
    logic        pc_write;
    logic        pc_write_cond;
    logic        branch_ne;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        reg_write;
    reg_dst_t    reg_dst;
    mem_to_reg_t mem_to_reg;
    logic        alu_src_a;
    alu_src_b_t  alu_src_b;
    alu_op_t     alu_op;
    pc_source_t  pc_source;
    logic        retire;
    logic        trap;
  } ctrl_t;

  function automatic logic is_imm_op(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational state -> control-word table for the multi-cycle controller.
module control_decode
  import mips_pkg::*;
(
  input  state_t      state,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output ctrl_t       ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE:    ctrl.alu_src_b = SRCB_IMM_SH2;
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_MDR;
        ctrl.retire     = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
        ctrl.retire    = mem_ready;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = RDST_RD;
        ctrl.retire    = 1'b1;
      end
      S_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_IMM;
      end
      S_I_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.retire    = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.branch_ne     = (opcode == OP_BNE);
        ctrl.retire        = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.retire    = 1'b1;
      end
      S_JAL: begin
        // PC already holds PC+4 here, so the link value is the live PC.
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = RDST_RA;
        ctrl.mem_to_reg = M2R_PC;
        ctrl.retire     = 1'b1;
      end
      S_JR: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_REG;
        ctrl.retire    = 1'b1;
      end
      S_TRAP:  ctrl.trap = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS32 control FSM: next-state sequencing, retired-instruction
// counter and illegal-opcode trap; control outputs come from control_decode.
module multicycle_control
  import mips_pkg::*;
#(
  parameter int unsigned RETIRE_W = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                branch_ne,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic [1:0]          reg_dst,
  output logic [1:0]          mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_source,
  output logic [3:0]          state,
  output logic                retire,
  output logic [RETIRE_W-1:0] instret,
  output logic                trap
);

  state_t cur_state, nxt_state;
  ctrl_t  ctrl;

  // The branch decision is resolved in the datapath from zero and branch_ne.
  logic unused_zero;
  assign unused_zero = zero;

  control_decode u_decode (
    .state     (cur_state),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_IDLE:      nxt_state = S_FETCH;
      S_FETCH:     if (mem_ready) nxt_state = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_LW || opcode == OP_SW)  nxt_state = S_MEM_ADDR;
        else if (opcode == OP_RTYPE)             nxt_state = (funct == FN_JR) ? S_JR : S_R_EXEC;
        else if (is_imm_op(opcode))              nxt_state = S_I_EXEC;
        else if (opcode == OP_BEQ || opcode == OP_BNE) nxt_state = S_BRANCH;
        else if (opcode == OP_J)                 nxt_state = S_JUMP;
        else if (opcode == OP_JAL)               nxt_state = S_JAL;
        else                                     nxt_state = S_TRAP;
      end
      S_MEM_ADDR:  nxt_state = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) nxt_state = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) nxt_state = S_FETCH;
      S_R_EXEC:    nxt_state = S_R_WB;
      S_I_EXEC:    nxt_state = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JAL, S_JR: nxt_state = S_FETCH;
      S_TRAP:      nxt_state = S_TRAP;
      default:     nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur_state <= S_IDLE;
      instret   <= '0;
    end else begin
      cur_state <= nxt_state;
      if (ctrl.retire) instret <= instret + RETIRE_W'(1);
    end
  end

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign branch_ne     = ctrl.branch_ne;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign reg_write     = ctrl.reg_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign retire        = ctrl.retire;
  assign trap          = ctrl.trap;
  assign state         = cur_state;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore/Mealy FSM that sequences the multi-cycle MIPS32 datapath: PC, instruction/data memory port, IR, ALU muxes and the register file write port.
- Consumes the IR opcode/funct fields, the ALU zero flag and a memory ready handshake.
- Drives every datapath enable and mux select.
- Keeps a retired-instruction counter and traps on unsupported opcodes.

Parameters:
- RETIRE_W, 32, width of retired-instruction counter (wraps modulo 2^RETIRE_W)

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, valid in BRANCH state
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  conditional PC load; datapath gates with the branch outcome
- branch_ne  out  1  1 = BNE, so the datapath uses ~zero
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- reg_write  out  1  register file write_enable
- reg_dst  out  2  write_reg select: 00 rt, 01 rd, 10 $31
- mem_to_reg  out  2  write_data select: 00 ALUOut, 01 MDR, 10 PC
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded, 11 opcode-decoded immediate op
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 A (jr)
- state  out  4  current state, for debug
- retire  out  1  one-cycle pulse on instruction completion
- instret  out  RETIRE_W  retired-instruction count
- trap  out  1  illegal instruction, sticky until reset

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, instret=0, trap=0.
  - All outputs 0 in IDLE.
  - Reset mid-instruction aborts immediately; there is no partial write, because outputs drop with the state.
- Unlisted outputs are 0 in each state; control outputs decode combinationally from state (plus mem_ready/zero where stated).
- IDLE -> FETCH unconditionally after one cycle.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=pc_write=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE on mem_ready=1.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Next state by opcode:
    - 0x23/0x2B -> MEM_ADDR
    - 0x00 with funct 0x08 -> JR
    - other 0x00 -> R_EXEC
    - 0x08/0x0C/0x0D/0x0A -> I_EXEC
    - 0x04/0x05 -> BRANCH
    - 0x02 -> JUMP
    - 0x03 -> JAL
    - anything else -> TRAP
- MEM_ADDR:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next: lw -> MEM_READ, sw -> MEM_WRITE.
- MEM_READ: mem_read=1, i_or_d=1; waits for mem_ready, then -> MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01; -> FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1; waits for mem_ready, then -> FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; -> R_WB.
- R_WB: reg_write=1, reg_dst=01, mem_to_reg=00; -> FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=11; -> I_WB.
- I_WB: reg_write=1, reg_dst=00, mem_to_reg=00; -> FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, branch_ne=(opcode==0x05).
  - -> FETCH.
- JUMP: pc_write=1, pc_source=10; -> FETCH.
- JAL:
  - Outputs: pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10.
  - $31 receives the pre-edge PC (already PC+4).
  - -> FETCH.
- JR: pc_write=1, pc_source=11; -> FETCH.
- TRAP: trap=1, all other controls 0; absorbing until reset.
- Retire and instret:
  - retire=1 in the completing cycle of MEM_WB, R_WB, I_WB, BRANCH, JUMP, JAL, JR, and of MEM_WRITE only when mem_ready=1.
  - instret increments on the same edge and wraps from all-ones to 0.
- Writes to $0: the controller still asserts reg_write; the register file drops them.
- mem_read and mem_write are never both 1.
- Instruction latencies with mem_ready tied 1:
  - lw 5 cycles
  - sw 4 cycles
  - R-type, I-type and jal-class: R/I 4 cycles; jal, j and jr 3 cycles
  - branch 3 cycles

Decomposition:
- Shared package mips_pkg holds:
  - state encodings (IDLE..TRAP, 4 bits)
  - opcode/funct constants
  - alu_op, alu_src_b, pc_source, reg_dst and mem_to_reg select encodings
- Sub-module: control_decode (combinational state->control-word table), instantiated by the FSM.
- Next-state logic and counters stay in multicycle_control.

Test Plan:
1. Reset/IDLE/add: reset_n low mid-MEM_READ, release.
   - Required: state=IDLE, all outputs 0, instret=0; FETCH on the next cycle.
   - Then add (opcode 0x00, funct 0x20) with mem_ready=1: states FETCH, DECODE, R_EXEC, R_WB; reg_write=1 only in R_WB, reg_dst=01; retire pulse; instret=1.
2. lw with wait states: mem_ready=0 for 3 cycles in FETCH and 2 cycles in MEM_READ.
   - Required: ir_write/pc_write are 1 only in the ready cycle; mem_read is held steady throughout; total 10 cycles; MEM_WB asserts mem_to_reg=01.
3. beq and bne: zero=1 and zero=0 for each.
   - Required: pc_write_cond=1, pc_source=01 in BRANCH; branch_ne=0 for 0x04, 1 for 0x05; retire each.
4. jal then jr (funct 0x08).
   - Required: JAL asserts reg_dst=10, mem_to_reg=10, pc_write=1, pc_source=10.
   - JR asserts pc_source=11, reg_write=0.
5. Illegal opcode 0x3F.
   - Required: DECODE -> TRAP; trap=1 persists across 20 cycles; instret unchanged; reset clears it.
6. instret wrap: RETIRE_W=4, run 17 single-instruction jumps (opcode 0x02).
   - Required: instret wraps 15 -> 0 and then reads 1.
